// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, legal oversampling ratios
// and the parity/majority helpers used by both the RX and TX paths.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } rx_state_t;

    localparam int PRESC_8   = 8;
    localparam int PRESC_16  = 16;
    localparam int PRESC_32  = 32;

    // Zero-extension does not change XOR parity, so one wide helper serves any data width.
    localparam int PAR_MAX_W = 32;

    function automatic logic par_calc(input logic [PAR_MAX_W-1:0] data, input logic typ);
        return (^data) ^ typ;
    endfunction

    function automatic logic maj3(input logic [2:0] s);
        return (s[0] & s[1]) | (s[0] & s[2]) | (s[1] & s[2]);
    endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Parallel-side and line-side signals of the UART receiver; the driver of the
// serial line and configuration uses master, the receiver uses slave.
interface uart_rx_if #(
    parameter int DATA_WIDTH = 8,
    parameter int PRESCALE_W = 6
);
    logic                  RX_IN;
    logic [PRESCALE_W-1:0] Prescale;
    logic                  PAR_EN;
    logic                  PAR_TYP;
    logic [DATA_WIDTH-1:0] P_DATA;
    logic                  data_valid;
    logic                  par_err;
    logic                  stp_err;

    modport master (
        output RX_IN, Prescale, PAR_EN, PAR_TYP,
        input  P_DATA, data_valid, par_err, stp_err
    );

    modport slave (
        input  RX_IN, Prescale, PAR_EN, PAR_TYP,
        output P_DATA, data_valid, par_err, stp_err
    );
endinterface

// File: rtl/uart_rx_sampler.sv
// Mid-bit 3-sample majority voter: captures the line around the bit centre and
// flags the resolve point two edges after the last sample.
module uart_rx_sampler
    import uart_pkg::*;
#(
    parameter int PRESCALE_W = 6
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  rx_in,
    input  logic [PRESCALE_W-1:0] edge_cnt,
    input  logic [PRESCALE_W-1:0] prescale,
    output logic                  sampled_bit,
    output logic                  sample_done
);
    logic [PRESCALE_W-1:0] half_s;
    logic [2:0]            samp_r;

    assign half_s = prescale >> 1'b1;

    // Capture the line on the three edges straddling mid-bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            samp_r <= 3'b111;
        end else if (edge_cnt == half_s - PRESCALE_W'(1)) begin
            samp_r[0] <= rx_in;
        end else if (edge_cnt == half_s) begin
            samp_r[1] <= rx_in;
        end else if (edge_cnt == half_s + PRESCALE_W'(1)) begin
            samp_r[2] <= rx_in;
        end else begin
            samp_r <= samp_r;
        end
    end

    assign sampled_bit = maj3(samp_r);
    assign sample_done = (edge_cnt == half_s + PRESCALE_W'(2));

endmodule

// File: rtl/uart_rx.sv
// UART receiver: start detection, per-bit majority sampling, LSB-first
// deserialization and parity/stop checking on a Prescale-oversampled clock.
module uart_rx
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int PRESCALE_W = 6
) (
    input logic      CLK,
    input logic      RST,
    uart_rx_if.slave bus
);
    localparam int BIT_CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(DATA_WIDTH - 1);

    rx_state_t             state_r;
    logic [PRESCALE_W-1:0] edge_cnt_r;
    logic [PRESCALE_W-1:0] presc_r;
    logic [BIT_CNT_W-1:0]  bit_cnt_r;
    logic [DATA_WIDTH-1:0] data_r;
    logic [DATA_WIDTH-1:0] p_data_r;
    logic                  par_en_r;
    logic                  par_typ_r;
    logic                  par_fail_r;
    logic                  data_valid_r;
    logic                  par_err_r;
    logic                  stp_err_r;
    logic                  sampled_bit_s;
    logic                  sample_done_s;
    logic                  bit_end_s;
    logic                  exp_par_s;

    assign bit_end_s = (edge_cnt_r == presc_r - PRESCALE_W'(1));
    assign exp_par_s = par_calc(PAR_MAX_W'(data_r), par_typ_r);

    uart_rx_sampler #(
        .PRESCALE_W (PRESCALE_W)
    ) u_sampler (
        .clk         (CLK),
        .rst_n       (RST),
        .rx_in       (bus.RX_IN),
        .edge_cnt    (edge_cnt_r),
        .prescale    (presc_r),
        .sampled_bit (sampled_bit_s),
        .sample_done (sample_done_s)
    );

    // Frame FSM with edge/bit counters, deserializer and registered result pulses.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_r      <= IDLE;
            edge_cnt_r   <= '0;
            bit_cnt_r    <= '0;
            presc_r      <= PRESCALE_W'(PRESC_8);
            par_en_r     <= 1'b0;
            par_typ_r    <= 1'b0;
            par_fail_r   <= 1'b0;
            data_r       <= '0;
            p_data_r     <= '0;
            data_valid_r <= 1'b0;
            par_err_r    <= 1'b0;
            stp_err_r    <= 1'b0;
        end else begin
            data_valid_r <= 1'b0;
            par_err_r    <= 1'b0;
            stp_err_r    <= 1'b0;

            if (state_r != IDLE) begin
                edge_cnt_r <= bit_end_s ? '0 : edge_cnt_r + PRESCALE_W'(1);
            end else begin
                edge_cnt_r <= '0;
            end

            case (state_r)
                IDLE: begin
                    if (!bus.RX_IN) begin
                        state_r    <= START;
                        presc_r    <= bus.Prescale;
                        par_en_r   <= bus.PAR_EN;
                        par_typ_r  <= bus.PAR_TYP;
                        par_fail_r <= 1'b0;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                START: begin
                    // A start bit that resolves high was line noise: drop it silently.
                    if (sample_done_s && sampled_bit_s) begin
                        state_r    <= IDLE;
                        edge_cnt_r <= '0;
                    end else if (bit_end_s) begin
                        state_r   <= DATA;
                        bit_cnt_r <= '0;
                    end else begin
                        state_r <= START;
                    end
                end
                DATA: begin
                    if (sample_done_s) begin
                        data_r[bit_cnt_r] <= sampled_bit_s;
                    end
                    if (bit_end_s) begin
                        if (bit_cnt_r == LAST_BIT) begin
                            bit_cnt_r <= '0;
                            state_r   <= par_en_r ? PARITY : STOP;
                        end else begin
                            bit_cnt_r <= bit_cnt_r + BIT_CNT_W'(1);
                        end
                    end
                end
                PARITY: begin
                    if (sample_done_s) begin
                        par_fail_r <= (sampled_bit_s != exp_par_s);
                    end
                    if (bit_end_s) begin
                        state_r <= STOP;
                    end
                end
                STOP: begin
                    if (sample_done_s) begin
                        stp_err_r <= ~sampled_bit_s;
                        par_err_r <= par_fail_r;
                        if (sampled_bit_s && !par_fail_r) begin
                            p_data_r     <= data_r;
                            data_valid_r <= 1'b1;
                        end
                    end
                    // A low line on the last stop edge is the next start bit.
                    if (bit_end_s) begin
                        if (!bus.RX_IN) begin
                            state_r    <= START;
                            presc_r    <= bus.Prescale;
                            par_en_r   <= bus.PAR_EN;
                            par_typ_r  <= bus.PAR_TYP;
                            par_fail_r <= 1'b0;
                        end else begin
                            state_r <= IDLE;
                        end
                    end
                end
                default: begin
                    state_r    <= IDLE;
                    edge_cnt_r <= '0;
                end
            endcase
        end
    end

    assign bus.P_DATA     = p_data_r;
    assign bus.data_valid = data_valid_r;
    assign bus.par_err    = par_err_r;
    assign bus.stp_err    = stp_err_r;

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: directed frames plus randomized frames checked against a
// frame-level reference model of the expected pulses and held P_DATA.
module tb_uart_rx;
    import uart_pkg::*;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    int          cyc   = 0;
    int          n_cmp = 0;
    int          n_bad = 0;
    int          pe_cnt = 0;
    int          se_cnt = 0;
    int          dv_cyc_q[$];
    logic [7:0]  dv_dat_q[$];
    logic [7:0]  model_pdata = 8'h00;
    int          stop_cyc = 0;
    int          presc_tab[3] = '{PRESC_8, PRESC_16, PRESC_32};

    uart_rx_if #(.DATA_WIDTH(8), .PRESCALE_W(6)) bus ();

    uart_rx #(.DATA_WIDTH(8), .PRESCALE_W(6)) dut (
        .CLK (clk),
        .RST (rst_n),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Output monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.data_valid) begin
                dv_cyc_q.push_back(cyc);
                dv_dat_q.push_back(bus.P_DATA);
            end
            if (bus.par_err) pe_cnt <= pe_cnt + 1;
            if (bus.stp_err) se_cnt <= se_cnt + 1;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive_bit(input logic b, input int p);
        bus.RX_IN = b;
        tick(p);
    endtask

    task automatic send_frame(input logic [7:0] data, input int presc, input logic par_en,
                              input logic par_typ, input logic par_bit, input logic stop_bit,
                              input bit scramble);
        bus.Prescale = 6'(presc);
        bus.PAR_EN   = par_en;
        bus.PAR_TYP  = par_typ;
        bus.RX_IN    = 1'b0;
        tick(1);
        if (scramble) begin
            bus.Prescale = 6'(presc_tab[$urandom_range(0, 2)]);
            bus.PAR_EN   = ~par_en;
            bus.PAR_TYP  = ~par_typ;
        end
        tick(presc - 1);
        for (int i = 0; i < 8; i++) drive_bit(data[i], presc);
        if (par_en) drive_bit(par_bit, presc);
        stop_cyc = cyc;
        drive_bit(stop_bit, presc);
    endtask

    // Reference: a frame is accepted only if the parity (when present) matches the
    // count-of-ones rule and the stop bit is 1; otherwise the matching error pulses.
    task automatic run_frame(input string tag, input logic [7:0] data, input int presc,
                             input logic par_en, input logic par_typ, input bit bad_par,
                             input logic stop_bit, input bit scramble);
        logic good_par, exp_pe, exp_se, exp_valid;
        int   dv0, pe0, se0;
        dv0 = dv_cyc_q.size();
        pe0 = pe_cnt;
        se0 = se_cnt;
        good_par  = (($countones(data) % 2) == 1) ^ par_typ;
        exp_pe    = par_en && bad_par;
        exp_se    = !stop_bit;
        exp_valid = !exp_pe && !exp_se;
        send_frame(data, presc, par_en, par_typ, good_par ^ bad_par, stop_bit, scramble);
        bus.RX_IN = 1'b1;
        tick(4);
        if (exp_valid) model_pdata = data;
        check_eq({tag, ".dv_count"}, dv_cyc_q.size() - dv0, {31'd0, exp_valid});
        if (exp_valid && dv_cyc_q.size() == dv0 + 1) begin
            check_eq({tag, ".dv_data"}, {24'd0, dv_dat_q[dv0]}, {24'd0, data});
            check_eq({tag, ".dv_in_stop_bit"},
                     {31'd0, (dv_cyc_q[dv0] >= stop_cyc + presc / 2) &&
                             (dv_cyc_q[dv0] <= stop_cyc + presc + 1)}, 32'd1);
        end
        check_eq({tag, ".par_err"}, pe_cnt - pe0, {31'd0, exp_pe});
        check_eq({tag, ".stp_err"}, se_cnt - se0, {31'd0, exp_se});
        check_eq({tag, ".p_data"}, {24'd0, bus.P_DATA}, {24'd0, model_pdata});
    endtask

    initial begin
        int dv0, pe0, se0;
        bus.RX_IN    = 1'b1;
        bus.Prescale = 6'd8;
        bus.PAR_EN   = 1'b0;
        bus.PAR_TYP  = 1'b0;
        tick(3);
        check_eq("reset.p_data", {24'd0, bus.P_DATA}, 32'd0);
        check_eq("reset.data_valid", {31'd0, bus.data_valid}, 32'd0);
        check_eq("reset.par_err", {31'd0, bus.par_err}, 32'd0);
        check_eq("reset.stp_err", {31'd0, bus.stp_err}, 32'd0);
        rst_n = 1'b1;
        tick(5);

        run_frame("b3_p8", 8'hB3, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        run_frame("5a_even_ok", 8'h5A, 16, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        run_frame("5a_even_bad", 8'h5A, 16, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        run_frame("00_odd_stop0", 8'h00, 32, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);

        // Two-cycle low glitch on an idle line.
        dv0 = dv_cyc_q.size(); pe0 = pe_cnt; se0 = se_cnt;
        bus.Prescale = 6'd8;
        bus.RX_IN    = 1'b0;
        tick(2);
        bus.RX_IN    = 1'b1;
        tick(20);
        check_eq("glitch.dv_count", dv_cyc_q.size() - dv0, 32'd0);
        check_eq("glitch.par_err", pe_cnt - pe0, 32'd0);
        check_eq("glitch.stp_err", se_cnt - se0, 32'd0);
        check_eq("glitch.p_data", {24'd0, bus.P_DATA}, {24'd0, model_pdata});

        // Back-to-back frames with no idle gap.
        dv0 = dv_cyc_q.size();
        send_frame(8'h11, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        send_frame(8'hEE, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        bus.RX_IN = 1'b1;
        tick(4);
        model_pdata = 8'hEE;
        check_eq("b2b.dv_count", dv_cyc_q.size() - dv0, 32'd2);
        if (dv_cyc_q.size() == dv0 + 2) begin
            check_eq("b2b.first", {24'd0, dv_dat_q[dv0]}, 32'h11);
            check_eq("b2b.second", {24'd0, dv_dat_q[dv0 + 1]}, 32'hEE);
            check_eq("b2b.spacing", dv_cyc_q[dv0 + 1] - dv_cyc_q[dv0], 32'd80);
        end
        check_eq("b2b.p_data", {24'd0, bus.P_DATA}, {24'd0, model_pdata});

        // Reset in the middle of the 4th data bit of 0xFF.
        bus.Prescale = 6'd8;
        bus.RX_IN    = 1'b0;
        tick(8);
        bus.RX_IN    = 1'b1;
        tick(28);
        rst_n = 1'b0;
        #1;
        model_pdata = 8'h00;
        check_eq("midrst.p_data", {24'd0, bus.P_DATA}, 32'd0);
        check_eq("midrst.data_valid", {31'd0, bus.data_valid}, 32'd0);
        check_eq("midrst.par_err", {31'd0, bus.par_err}, 32'd0);
        check_eq("midrst.stp_err", {31'd0, bus.stp_err}, 32'd0);
        tick(3);
        rst_n = 1'b1;
        dv0 = dv_cyc_q.size(); pe0 = pe_cnt; se0 = se_cnt;
        tick(60);
        check_eq("midrst.no_pulse", (dv_cyc_q.size() - dv0) + (pe_cnt - pe0) + (se_cnt - se0), 32'd0);
        run_frame("3c_after_rst", 8'h3C, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

        // Randomized frames with mid-frame configuration scrambling.
        for (int n = 0; n < 24; n++) begin
            logic [7:0] d;
            int         p;
            logic       pen, ptyp, stp;
            bit         badp;
            d    = 8'($urandom_range(0, 255));
            p    = presc_tab[$urandom_range(0, 2)];
            pen  = 1'($urandom_range(0, 1));
            ptyp = 1'($urandom_range(0, 1));
            badp = ($urandom_range(0, 3) == 0);
            stp  = ($urandom_range(0, 4) != 0);
            run_frame($sformatf("rand%0d", n), d, p, pen, ptyp, badp, stp, 1'b1);
            tick($urandom_range(0, 6));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- UART receive path: recovers frames from the serial line and deserializes them into parallel bytes.
- Pairs with the UART TX serializer/FSM; frame format is start(0), DATA_WIDTH data bits LSB first, optional parity, one stop(1).
- Runs on an oversampling clock at Prescale × baud rate.
- Each bit is resolved by a 3-sample majority vote around mid-bit.
- Delivers P_DATA with a one-cycle data_valid pulse, plus parity and stop error flags.

Parameters:
- DATA_WIDTH, 8, number of data bits per frame.
- PRESCALE_W, 6, width of the Prescale input and the edge counter.

Ports:
- CLK  input  1  oversampling clock (Prescale × baud).
- RST  input  1  asynchronous reset, active-low.
- RX_IN  input  1  serial line; idles at 1.
- Prescale  input  PRESCALE_W  oversampling ratio; legal values 8, 16, 32.
- PAR_EN  input  1  1 means a parity bit is present.
- PAR_TYP  input  1  0 is even parity, 1 is odd parity.
- P_DATA  output  DATA_WIDTH  last received byte; holds until the next valid frame.
- data_valid  output  1  one-cycle pulse; P_DATA is valid in that cycle.
- par_err  output  1  one-cycle pulse on parity mismatch.
- stp_err  output  1  one-cycle pulse when the stop bit is sampled 0.

Behaviour:
- Reset (RST=0, async):
  - State goes to IDLE.
  - Counters clear.
  - P_DATA=0, data_valid=0, par_err=0, stp_err=0.
- Config latching: Prescale, PAR_EN and PAR_TYP are latched on the IDLE→START transition. Changes mid-frame are ignored.
- Edge counter (edge_cnt):
  - Counts 0..Prescale-1 within each bit; wraps to 0 at the end of the bit and increments bit_cnt.
  - Sample points are edge_cnt = Prescale/2-1, Prescale/2 and Prescale/2+1.
  - The bit value is the majority of those 3 samples, registered at edge_cnt = Prescale/2+2.
- FSM states and transitions:
  - IDLE: when RX_IN=0, go to START with edge_cnt=0 on the same cycle.
  - START: at the resolve point, a sampled 1 is a glitch. Return to IDLE immediately, with no error and no output pulse. A sampled 0 continues to the end of the bit, then goes to DATA.
  - DATA: shift the resolved bit into position bit_cnt (LSB first). After DATA_WIDTH bits, go to PARITY if PAR_EN=1, else to STOP.
  - PARITY: expected parity is ^data XOR PAR_TYP. A mismatch sets an internal par_fail flag.
  - STOP: resolved at the stop bit's sample point.
- Outputs after the STOP resolve point (same cycle as resolution, registered):
  - Stop bit 0: stp_err=1 for one cycle.
  - par_fail set: par_err=1 for one cycle.
  - Both may pulse together.
  - Neither set: P_DATA is loaded and data_valid=1 for one cycle.
  - P_DATA is NOT updated on any error.
- End of frame:
  - The FSM stays in STOP until edge_cnt = Prescale-1, then goes to IDLE.
  - If RX_IN=0 in that final cycle, it goes directly to START (back-to-back frames, no idle gap needed).
- Latency: data_valid fires (Prescale/2+3) cycles into the stop bit.
- Reset mid-frame aborts immediately. No partial pulse is produced, and P_DATA returns to 0.
- An illegal Prescale (not 8/16/32) leaves behaviour undefined. No checking is done in RTL.

Decomposition:
- Shared package uart_pkg holds:
  - State encoding localparams IDLE/START/DATA/PARITY/STOP (3-bit).
  - Legal prescale constants PRESC_8/16/32.
  - The parity function par_calc(data, typ), shared with the TX side.
- One sub-module, uart_rx_sampler:
  - Inputs: RX_IN, edge_cnt, Prescale.
  - Outputs: sampled_bit, sample_done.
  - Captures the 3 samples and asserts sample_done at the resolve point.
- Top-level uart_rx contains the FSM, the counters and the deserializer register.

Test Plan:
- Prescale=8, PAR_EN=0, send 0xB3 (line: 0,1,1,0,0,1,1,0,1,1) -> data_valid pulses once, P_DATA=8'hB3, par_err=0, stp_err=0.
- Prescale=16, PAR_EN=1, PAR_TYP=0, send 0x5A with parity bit 0 -> P_DATA=8'h5A with data_valid. Repeat with parity bit 1 -> par_err pulse, no data_valid, P_DATA stays 8'h5A.
- Prescale=32, PAR_EN=1, PAR_TYP=1, send 0x00 with parity 1 and stop bit 0 -> stp_err pulse, no data_valid.
- Start glitch: RX_IN low for 2 cycles at Prescale=8 -> FSM returns to IDLE, no pulses, P_DATA unchanged.
- Back-to-back frames 0x11 then 0xEE, no idle gap, Prescale=8 -> two data_valid pulses exactly 80 cycles apart, values 8'h11 then 8'hEE.
- Assert RST low during the 4th data bit of 0xFF -> all outputs 0 immediately. A subsequent frame 0x3C is received correctly.
